// File: rtl/main_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem_ctrl_if
//  Purpose  : Request/ack bus between the cache and the backing-store controller.
//  Revision : 1.0
// ============================================================================
interface main_mem_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 13
);
   logic              req;
   logic [1:0]        op;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              busy;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (
      output req, op, addr, wdata, wb_addr, wb_data,
      input  busy, ack, rdata, err
   );

   modport slave (
      input  req, op, addr, wdata, wb_addr, wb_data,
      output busy, ack, rdata, err
   );
endinterface
`default_nettype wire

// File: rtl/main_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem_ctrl
//  Purpose  : Slow word-array backing store servicing cache fills and victim
//             write-backs. Optional macro MAIN_MEM_STATS_EN adds access counters.
//  Revision : 1.0
// ============================================================================
module main_mem_ctrl #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 13,
   parameter int LATENCY = 4
) (
   input  wire logic         i_clock,
   input  wire logic         i_reset,
   main_mem_ctrl_if.slave    io_bus
`ifdef MAIN_MEM_STATS_EN
   ,
   output logic [15:0]       o_rd_count,
   output logic [15:0]       o_wr_count
`endif
);

   localparam int c_DEPTH = 2 ** ADDR_W;
   localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LATENCY - 1);

   localparam logic [1:0] c_OP_READ   = 2'b00;
   localparam logic [1:0] c_OP_WRITE  = 2'b01;
   localparam logic [1:0] c_OP_WBFILL = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_WB = 2'd1,
      S_WAIT    = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_CNT_W-1:0]  w_cnt_nxt;

   logic [1:0]          r_op;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [ADDR_W-1:0]   r_wb_addr;
   logic [DATA_W-1:0]   r_wb_data;

   logic [DATA_W-1:0]   r_mem [c_DEPTH];
   logic [DATA_W-1:0]   r_rdata;
   logic [DATA_W-1:0]   w_rdata_nxt;
   logic                r_busy;
   logic                r_ack;
   logic                r_err;

   logic                w_latch;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_waddr;
   logic [DATA_W-1:0]   w_mem_wdata;
   logic                w_mem_re;
   logic                w_err_nxt;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_waddr = r_addr;
      w_mem_wdata = r_wdata;
      w_mem_re    = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = r_rdata;

      case (r_state)
         S_IDLE: begin
            if (io_bus.req) begin
               w_latch   = 1'b1;
               w_cnt_nxt = c_CNT_INIT;
               case (io_bus.op)
                  c_OP_WBFILL: w_state_nxt = S_WAIT_WB;
                  c_OP_READ,
                  c_OP_WRITE:  w_state_nxt = S_WAIT;
                  default: begin
                     // Illegal op: one pass through WAIT with an expired counter,
                     // so the error ack lands one edge after acceptance.
                     w_state_nxt = S_WAIT;
                     w_cnt_nxt   = '0;
                  end
               endcase
            end
         end

         S_WAIT_WB: begin
            if (r_cnt == '0) begin
               w_mem_we    = 1'b1;
               w_mem_waddr = r_wb_addr;
               w_mem_wdata = r_wb_data;
               w_cnt_nxt   = c_CNT_INIT;
               w_state_nxt = S_WAIT;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_RESP;
               case (r_op)
                  c_OP_READ,
                  c_OP_WBFILL: begin
                     w_mem_re    = 1'b1;
                     w_rdata_nxt = r_mem[r_addr];
                  end
                  c_OP_WRITE: begin
                     w_mem_we    = 1'b1;
                     w_mem_waddr = r_addr;
                     w_mem_wdata = r_wdata;
                     w_rdata_nxt = r_wdata;
                  end
                  default: w_err_nxt = 1'b1;
               endcase
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         S_RESP: w_state_nxt = S_IDLE;

         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_op      <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else if (w_latch) begin
         r_op      <= io_bus.op;
         r_addr    <= io_bus.addr;
         r_wdata   <= io_bus.wdata;
         r_wb_addr <= io_bus.wb_addr;
         r_wb_data <= io_bus.wb_data;
      end
   end

   // Array resets to an identity pattern so every word holds its own address.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= DATA_W'(i);
         end
      end else if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rdata <= '0;
         r_busy  <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_rdata <= w_rdata_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_ack   <= (w_state_nxt == S_RESP);
         r_err   <= w_err_nxt;
      end
   end

   assign io_bus.busy  = r_busy;
   assign io_bus.ack   = r_ack;
   assign io_bus.rdata = r_rdata;
   assign io_bus.err   = r_err;

`ifdef MAIN_MEM_STATS_EN
   logic [15:0] r_rd_count;
   logic [15:0] r_wr_count;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_mem_re && (r_rd_count != 16'hFFFF)) begin
            r_rd_count <= r_rd_count + 16'd1;
         end
         if (w_mem_we && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
      end
   end

   assign o_rd_count = r_rd_count;
   assign o_wr_count = r_wr_count;
`else
   logic w_unused_re;
   assign w_unused_re = w_mem_re;
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_mem_ctrl
//  Purpose  : Scoreboard bench for main_mem_ctrl with directed transactions.
//  Revision : 1.0
// ============================================================================
module tb_main_mem_ctrl;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 13;
   localparam int LATENCY = 4;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_WBF = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
      int                ack_cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   exp_t q[$];

   main_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MAIN_MEM_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
`endif

   main_mem_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LATENCY(LATENCY)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .io_bus (bus)
`ifdef MAIN_MEM_STATS_EN
      ,
      .o_rd_count(rd_count),
      .o_wr_count(wr_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [DATA_W-1:0] rd, input logic e, input int ack_cyc);
      exp_t x;
      x.rdata   = rd;
      x.err     = e;
      x.ack_cyc = ack_cyc;
      q.push_back(x);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!bus.busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: busy still 1 after 40 cycles, required 0");
      end
   endtask

   // Issues one transaction, records the accepting edge, returns once idle again.
   task automatic do_txn(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] wba,
                         input logic [DATA_W-1:0] wbd, input logic [DATA_W-1:0] exp_rd,
                         input logic exp_err, input int lat);
      int acc;
      @(negedge clk);
      bus.req     = 1'b1;
      bus.op      = op;
      bus.addr    = a;
      bus.wdata   = wd;
      bus.wb_addr = wba;
      bus.wb_data = wbd;
      @(posedge clk);
      #1;
      acc = cyc;
      bus.req = 1'b0;
      push(exp_rd, exp_err, acc + lat);
      wait_idle();
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops an expectation on every ack and checks data, error and timing.
   initial begin
      exp_t e;
      logic prev_ack;
      prev_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ack = 1'b0;
         end else begin
            if (prev_ack) begin
               chk("ack_one_cycle", 32'(bus.ack), 32'd0);
               chk("busy_after_ack", 32'(bus.busy), 32'd0);
            end
            if (bus.ack) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ack: ack=1 with rdata 0x%0h, required no ack", bus.rdata);
               end else begin
                  e = q.pop_front();
                  chk("rdata", 32'(bus.rdata), 32'(e.rdata));
                  chk("err", 32'(bus.err), 32'(e.err));
                  chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                  chk("busy_in_resp", 32'(bus.busy), 32'd1);
               end
            end
            prev_ack = bus.ack;
         end
      end
   end

   initial begin
      int a0;
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.req     = 1'b0;
      bus.op      = OP_RD;
      bus.addr    = '0;
      bus.wdata   = '0;
      bus.wb_addr = '0;
      bus.wb_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_ack", 32'(bus.ack), 32'd0);
      chk("reset_err", 32'(bus.err), 32'd0);
      chk("reset_rdata", 32'(bus.rdata), 32'd0);
      rst = 1'b0;

      // Plain read of the identity pattern, then write/read-back at the top word.
      do_txn(OP_RD, 5'd5, 13'h0, 5'd0, 13'h0, 13'd5, 1'b0, LATENCY);
      do_txn(OP_WR, 5'd31, 13'h1ABC, 5'd0, 13'h0, 13'h1ABC, 1'b0, LATENCY);
      do_txn(OP_RD, 5'd31, 13'h0, 5'd0, 13'h0, 13'h1ABC, 1'b0, LATENCY);

      // Victim write-back followed by fill, distinct and aliased addresses.
      do_txn(OP_WBF, 5'd9, 13'h0, 5'd3, 13'h0F0, 13'd9, 1'b0, 2 * LATENCY);
      do_txn(OP_RD, 5'd3, 13'h0, 5'd0, 13'h0, 13'h0F0, 1'b0, LATENCY);
      do_txn(OP_WBF, 5'd7, 13'h0, 5'd7, 13'h1234, 13'h1234, 1'b0, 2 * LATENCY);

      // req held across three reads; addr changes while a read is waiting.
      @(negedge clk);
      bus.req  = 1'b1;
      bus.op   = OP_RD;
      bus.addr = 5'd10;
      @(posedge clk);
      #1;
      a0 = cyc;
      push(13'd10, 1'b0, a0 + LATENCY);
      push(13'd11, 1'b0, a0 + 2 * LATENCY + 2);
      push(13'd12, 1'b0, a0 + 3 * LATENCY + 4);
      wait_cyc(a0 + 2);
      bus.addr = 5'd11;
      wait_cyc(a0 + LATENCY + 2);
      wait_cyc(a0 + LATENCY + 4);
      bus.addr = 5'd12;
      wait_cyc(a0 + 2 * LATENCY + 4);
      bus.req = 1'b0;
      wait_cyc(a0 + 2 * LATENCY + 6);
      bus.addr = 5'd20;
      wait_idle();

      // Illegal op: quick error ack, rdata holds the previous read, array untouched.
      do_txn(OP_ILL, 5'd31, 13'h0000, 5'd31, 13'h0000, 13'd12, 1'b1, 1);
      do_txn(OP_RD, 5'd31, 13'h0, 5'd0, 13'h0, 13'h1ABC, 1'b0, LATENCY);

      // Reset during the write-back phase.
      @(negedge clk);
      bus.req     = 1'b1;
      bus.op      = OP_WBF;
      bus.addr    = 5'd6;
      bus.wb_addr = 5'd4;
      bus.wb_data = 13'h555;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_abort_busy", 32'(bus.busy), 32'd0);
      chk("reset_abort_ack", 32'(bus.ack), 32'd0);
`ifdef MAIN_MEM_STATS_EN
      chk("reset_rd_count", 32'(rd_count), 32'd0);
      chk("reset_wr_count", 32'(wr_count), 32'd0);
`endif
      rst = 1'b0;
      do_txn(OP_RD, 5'd4, 13'h0, 5'd0, 13'h0, 13'd4, 1'b0, LATENCY);
      do_txn(OP_WBF, 5'd31, 13'h0, 5'd8, 13'h0AA, 13'd31, 1'b0, 2 * LATENCY);
`ifdef MAIN_MEM_STATS_EN
      chk("rd_count", 32'(rd_count), 32'd2);
      chk("wr_count", 32'(wr_count), 32'd1);
`endif
      do_txn(OP_RD, 5'd8, 13'h0, 5'd0, 13'h0, 13'h0AA, 1'b0, LATENCY);
      do_txn(OP_RD, 5'd3, 13'h0, 5'd0, 13'h0, 13'd3, 1'b0, LATENCY);

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
